// File: rtl/restador_serial.sv
// restador_serial: bit-serial LSB-first subtractor producing A-B with borrow, overflow and zero flags.
module restador_serial #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] y,
  output logic             borrow,
  output logic             ovf,
  output logic             zero,
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0] state;
  logic [WIDTH-1:0] a_sh, b_sh, r_sh, r_nx;
  logic [CW-1:0] cnt;
  logic bin, bout, d, a_msb, b_msb, last, load;
  always_comb begin
    d    = a_sh[0] ^ b_sh[0] ^ bin;
    bout = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & bin);
    r_nx = {d, r_sh[WIDTH-1:1]};
    last = cnt == CW'(WIDTH - 1);
    load = start && state != CALC;
  end
  assign busy = state == CALC;
  assign done = state == DONE;
  // y and flags only change on the edge leaving CALC, so partial sums never show
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      r_sh   <= '0;
      cnt    <= '0;
      bin    <= 1'b0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      y      <= '0;
      borrow <= 1'b0;
      ovf    <= 1'b0;
      zero   <= 1'b0;
    end else if (load) begin
      state <= CALC;
      a_sh  <= A;
      b_sh  <= B;
      a_msb <= A[WIDTH-1];
      b_msb <= B[WIDTH-1];
      r_sh  <= '0;
      cnt   <= '0;
      bin   <= 1'b0;
    end else if (state == CALC) begin
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      r_sh <= r_nx;
      bin  <= bout;
      cnt  <= cnt + 1'b1;
      if (last) begin
        state  <= DONE;
        y      <= r_nx;
        borrow <= bout;
        ovf    <= (a_msb != b_msb) && (d != a_msb);
        zero   <= ~|r_nx;
      end
    end else begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_restador_serial.sv
// tb_restador_serial: directed and random checks of restador_serial against an arithmetic model.
module tb_restador_serial;
  logic clk = 1'b0;
  logic rst_n, start;
  logic [3:0] A, B, y;
  logic borrow, ovf, zero, busy, done;
  int total = 0, passed = 0;
  logic [3:0] exp_y = 4'd0;
  int busy_n, lat;
  bit got;

  restador_serial #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B),
    .y(y), .borrow(borrow), .ovf(ovf), .zero(zero), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_res(input logic [3:0] a, input logic [3:0] b);
    int sa, sb, sd;
    logic [3:0] ey;
    sa = (a > 7) ? int'(a) - 16 : int'(a);
    sb = (b > 7) ? int'(b) - 16 : int'(b);
    sd = sa - sb;
    ey = 4'((int'(a) - int'(b)) & 15);
    chk("y", y, ey);
    chk("borrow", borrow, a < b);
    chk("ovf", ovf, (sd > 7) || (sd < -8));
    chk("zero", zero, ey == 0);
    exp_y = ey;
  endtask

  // Caller has already driven A/B/start=1; returns at the done cycle.
  task automatic run_op(input bit wiggle);
    tick();
    start = 1'b0;
    busy_n = 0;
    got = 0;
    lat = 1;
    for (int i = 0; i < 20 && !got; i++) begin
      if (done) got = 1;
      else begin
        if (busy) busy_n++;
        chk("y_hold", y, exp_y);
        if (wiggle) begin
          A = 4'($urandom);
          B = 4'($urandom);
        end
        tick();
        lat++;
      end
    end
    chk("done_seen", got, 1);
  endtask

  task automatic op(input logic [3:0] a, input logic [3:0] b);
    A = a;
    B = b;
    start = 1'b1;
    run_op(1'b1);
    chk("busy_cycles", busy_n, 4);
    chk("latency", lat, 5);
    check_res(a, b);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b1;
    A = 4'd7;
    B = 4'd3;
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_y", y, 0);
    chk("rst_flags", {borrow, ovf, zero}, 0);
    start = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("idle_busy", busy, 0);

    op(4'd7, 4'd3);
    tick();
    chk("done_pulse", done, 0);
    chk("idle_y_hold", y, exp_y);
    op(4'd3, 4'd7);
    op(4'd8, 4'd1);
    op(4'd5, 4'd5);
    op(4'd6, 4'd0);

    // start during CALC ignored, then back-to-back from DONE
    A = 4'd9;
    B = 4'd2;
    start = 1'b1;
    tick();
    A = 4'd0;
    B = 4'd0;
    for (int i = 0; i < 3; i++) begin
      chk("b2b_busy", busy, 1);
      tick();
    end
    A = 4'd2;
    B = 4'd9;
    tick();
    chk("b2b_done1", done, 1);
    check_res(4'd9, 4'd2);
    run_op(1'b0);
    chk("b2b_busy_cycles", busy_n, 4);
    check_res(4'd2, 4'd9);

    // reset in second CALC cycle
    tick();
    A = 4'd7;
    B = 4'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_y", y, 0);
    chk("mid_rst_done", done, 0);
    exp_y = 4'd0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("post_rst_done", done, 0);
      chk("post_rst_busy", busy, 0);
      tick();
    end
    op(4'd15, 4'd15);

    for (int n = 0; n < 1000; n++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        tick();
        chk("gap_done", done, 0);
        chk("gap_busy", busy, 0);
        chk("gap_y", y, exp_y);
      end
      op(4'($urandom), 4'($urandom));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
